sdspi_ctrl_wb: RTL and testbench
================================

SDSPI_CTRL_WB -- requirements
Module: sdspi_ctrl_wb

Interface
REQ-001 SHALL have parameter DIV_RST, default 8'd3, reset value of the SCK divider field.
REQ-002 SHALL have port wb_clk_i, input, 1, system clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_ni, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have ports wb_adr_i in 32, wb_dat_i in 32, wb_dat_o out 32, wb_we_i in 1, wb_sel_i in 4 (ignored), wb_stb_i in 1, wb_cyc_i in 1, wb_ack_o out 1; Wishbone classic slave.
REQ-005 SHALL have ports sd_ss out 1 (active-low chip select), sd_sck out 1, sd_mosi out 1, sd_miso in 1; dedicated SD SPI bus.
REQ-006 SHALL have port irq, output, 1, high while DONE flag set and IE=1.

Function
REQ-007 Register map SHALL be decoded on wb_adr_i[3:2]: 0 CTRL, 1 DATA, 2 STATUS, 3 reserved (reads 0, writes ignored).
REQ-008 CTRL SHALL be: bit0 SS (drives sd_ss directly), bit1 IE, bits 15:8 DIV; readable back; other bits read 0.
REQ-009 STATUS SHALL be: bit0 BUSY, bit1 DONE (sticky), bit2 OVR (sticky); write of 1 to bit1/bit2 clears that flag.
REQ-010 wb_ack_o SHALL assert for exactly one cycle, one cycle after cyc&stb is first seen, and deassert the following cycle even if stb stays high (no back-to-back ack).
REQ-011 Read data SHALL be registered and valid in the ack cycle; DATA read returns {24'b0, rx byte}.
REQ-012 Write to DATA while idle SHALL load wb_dat_i[7:0] into the shift register, set BUSY, clear DONE, and start a transfer the next cycle.
REQ-013 Write to DATA while BUSY SHALL be acked, discarded, and set OVR; the transfer in progress is unaffected.
REQ-014 FSM states SHALL be IDLE, LOW, HIGH, FIN.
REQ-015 IDLE: sd_sck=0, sd_mosi=shift[7] of last loaded byte or 1 after reset; start -> LOW with sd_mosi=tx bit7, bit counter=7.
REQ-016 LOW: sd_sck=0 for DIV+1 clocks, then -> HIGH with sd_sck=1 and sd_miso sampled into the LSB side on that same edge (SPI mode 0).
REQ-017 HIGH: sd_sck=1 for DIV+1 clocks, then shift left, present next bit on sd_mosi, sd_sck=0; -> LOW if counter>0 (decrement) else -> FIN.
REQ-018 FIN: latch rx byte, clear BUSY, set DONE, -> IDLE; total transfer = 16*(DIV+1)+1 clocks from start.
REQ-019 Data SHALL be MSB first; DIV=0 gives SCK = wb_clk_i/2.
REQ-020 DIV and SS writes during a transfer SHALL take effect immediately (software responsibility); DIV change applies at next half-period count reload.
REQ-021 A DATA write coinciding with FIN SHALL be treated as BUSY (OVR set, byte dropped).
REQ-022 STATUS flag set and clear-write in the same cycle: set wins.

Reset
REQ-023 Asserting wb_rst_ni SHALL immediately force: sd_ss=1, sd_sck=0, sd_mosi=1, wb_ack_o=0, wb_dat_o=0, irq=0, SS=1, IE=0, DIV=DIV_RST, BUSY=DONE=OVR=0, rx byte=0, FSM=IDLE.
REQ-024 Reset mid-transfer SHALL abort without completing; no DONE set after release.
REQ-025 Deassertion SHALL be synchronised to wb_clk_i internally (two-flop) before releasing state.

Structure
REQ-026 A shared package SHALL hold register offsets, CTRL/STATUS bit positions and the FSM state encoding.
REQ-027 The byte shift engine (FSM, divider, counter) SHALL be one sub-module spi_byte_engine; the Wishbone register file wraps it.

Verification
REQ-028 Reset: after release, read CTRL -> 0x0000_0301, STATUS -> 0, sd_ss=1, sd_sck=0.
REQ-029 DIV=0, write DATA=0xA5, MISO loopback from MOSI -> 8 SCK pulses of 2 clocks each, MOSI 1,0,1,0,0,1,0,1, DATA read 0xA5, DONE set at clock 17.
REQ-030 DIV=3, MISO tied 1, write 0x00 -> SCK high 4 clocks each, rx 0xFF, BUSY high 65 clocks.
REQ-031 Write DATA 0x11 then 0x22 while BUSY -> only 0x11 shifted, OVR=1; write STATUS 0x4 -> OVR=0.
REQ-032 IE=1, complete transfer -> irq high; write STATUS 0x2 -> irq low.
REQ-033 Assert reset at bit 3 of a transfer -> outputs at reset values same cycle, DONE=0 after release.

Source files
------------

// File: rtl/sdspi_ctrl_wb_pkg.sv
// Shared definitions for the SD-card SPI controller: register offsets,
// CTRL/STATUS bit positions and the byte-engine state encoding.
package sdspi_ctrl_wb_pkg;

  // Register word offsets, decoded on wb_adr_i[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_SS      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_MSB = 15;

  // STATUS bit positions
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;

  // Byte engine states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_FIN  = 2'd3
  } spi_state_e;

  // Assemble the CTRL readback word from its fields
  function automatic logic [31:0] ctrl_word(input logic ss, input logic ie,
                                            input logic [7:0] div);
    return {16'b0, div, 6'b0, ie, ss};
  endfunction

endpackage

// File: rtl/sdspi_ctrl_wb_spi_byte_engine.sv
// SPI mode-0 byte shifter: half-period divider, bit counter and the
// IDLE/LOW/HIGH/FIN sequencer. MSB first, MISO sampled on SCK rise.
module spi_byte_engine
  import sdspi_ctrl_wb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic [7:0] i_div,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_fin,
  output logic [7:0] o_rx
);

  spi_state_e r_state;
  spi_state_e w_next;
  logic [7:0] r_shift;
  logic [7:0] r_cnt;
  logic [2:0] r_bit;
  logic       r_sample;
  logic       r_mosi;
  logic [7:0] r_rx;
  logic       w_tick;

  // Half-period expires when the divider count reaches zero
  assign w_tick = (r_cnt == 8'd0);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_LOW;
      S_LOW:  if (w_tick)  w_next = S_HIGH;
      S_HIGH: if (w_tick)  w_next = (r_bit == 3'd0) ? S_FIN : S_LOW;
      S_FIN:               w_next = S_IDLE;
      default:             w_next = S_IDLE;
    endcase
  end

  // Shift register, divider, bit counter and MOSI/RX datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= 8'd0;
      r_cnt    <= 8'd0;
      r_bit    <= 3'd0;
      r_sample <= 1'b0;
      r_mosi   <= 1'b1;
      r_rx     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shift <= i_tx;
            r_mosi  <= i_tx[7];
            r_bit   <= 3'd7;
            r_cnt   <= i_div;
          end
        end
        S_LOW: begin
          if (w_tick) begin
            r_sample <= i_miso;
            r_cnt    <= i_div;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            r_shift <= {r_shift[6:0], r_sample};
            r_mosi  <= r_shift[6];
            r_cnt   <= i_div;
            if (r_bit != 3'd0) r_bit <= r_bit - 3'd1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_FIN: begin
          r_rx <= r_shift;
        end
        default: ;
      endcase
    end
  end

  assign o_sck  = (r_state == S_HIGH);
  assign o_mosi = r_mosi;
  assign o_fin  = (r_state == S_FIN);
  assign o_rx   = r_rx;

endmodule

// File: rtl/sdspi_ctrl_wb.sv
// Wishbone classic register file wrapping the SPI byte engine for an
// SD card: CTRL (SS/IE/DIV), DATA (tx/rx byte) and STATUS (BUSY/DONE/OVR).
module sdspi_ctrl_wb
  import sdspi_ctrl_wb_pkg::*;
#(
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        sd_ss,
  output logic        sd_sck,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        irq
);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic        r_ack;
  logic [31:0] r_dat_o;
  logic        r_ss;
  logic        r_ie;
  logic [7:0]  r_div;
  logic        r_busy;
  logic        r_done;
  logic        r_ovr;
  logic        w_req;
  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic [1:0]  w_reg;
  logic        w_data_wr;
  logic        w_start;
  logic        w_ovr_set;
  logic        w_stat_wr;
  logic        w_fin;
  logic [7:0]  w_rx;
  logic [31:0] w_rdata;
  logic        w_unused;

  // Reset asserts at once, releases two clocks after wb_rst_ni rises
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Bus decode: an access happens on the cycle the ack is raised
  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_acc     = w_req & ~r_ack;
  assign w_wr      = w_acc & wb_we_i;
  assign w_rd      = w_acc & ~wb_we_i;
  assign w_reg     = wb_adr_i[3:2];
  assign w_data_wr = w_wr && (w_reg == REG_DATA);
  assign w_stat_wr = w_wr && (w_reg == REG_STATUS);
  // BUSY stays set through FIN, so a DATA write on that cycle is an overrun
  assign w_start   = w_data_wr & ~r_busy;
  assign w_ovr_set = w_data_wr & r_busy;

  // Single-cycle ack; never acks two cycles in a row
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_ack <= 1'b0;
    else          r_ack <= w_acc;
  end

  // CTRL register
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ss  <= 1'b1;
      r_ie  <= 1'b0;
      r_div <= DIV_RST;
    end else if (w_wr && (w_reg == REG_CTRL)) begin
      r_ss  <= wb_dat_i[CTRL_SS];
      r_ie  <= wb_dat_i[CTRL_IE];
      r_div <= wb_dat_i[CTRL_DIV_MSB:CTRL_DIV_LSB];
    end
  end

  // STATUS flags; a hardware set beats a software clear on the same cycle
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      if (w_start)    r_busy <= 1'b1;
      else if (w_fin) r_busy <= 1'b0;

      if (w_fin)                              r_done <= 1'b1;
      else if (w_start)                       r_done <= 1'b0;
      else if (w_stat_wr && wb_dat_i[ST_DONE]) r_done <= 1'b0;

      if (w_ovr_set)                          r_ovr <= 1'b1;
      else if (w_stat_wr && wb_dat_i[ST_OVR]) r_ovr <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      REG_CTRL:   w_rdata = ctrl_word(r_ss, r_ie, r_div);
      REG_DATA:   w_rdata = {24'd0, w_rx};
      REG_STATUS: w_rdata = {29'd0, r_ovr, r_done, r_busy};
      default:    w_rdata = 32'd0;
    endcase
  end

  // Registered read data, presented only in the ack cycle
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_dat_o <= 32'd0;
    else          r_dat_o <= w_rd ? w_rdata : 32'd0;
  end

  spi_byte_engine u_engine (
    .i_clk   (wb_clk_i),
    .i_rst_n (w_rst_n),
    .i_start (w_start),
    .i_tx    (wb_dat_i[7:0]),
    .i_div   (r_div),
    .i_miso  (sd_miso),
    .o_sck   (sd_sck),
    .o_mosi  (sd_mosi),
    .o_fin   (w_fin),
    .o_rx    (w_rx)
  );

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat_o;
  assign sd_ss    = r_ss;
  assign irq      = r_done & r_ie;

  // Address/select/data bits with no function in this register map
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

endmodule

// File: tb/tb_sdspi_ctrl_wb.sv
module tb_sdspi_ctrl_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        ack;
  logic        ss, sck, mosi, miso, irq;
  logic        loop_en = 1'b1;
  logic        miso_tie = 1'b1;

  int checks = 0;
  int errors = 0;
  int exp_hi = 1;

  typedef struct packed {
    logic        chk;
    logic [31:0] val;
  } exp_t;
  exp_t  ackq[$];
  string nameq[$];
  logic  bitq[$];

  assign miso = loop_en ? mosi : miso_tie;

  always #5 clk = ~clk;

  sdspi_ctrl_wb #(.DIV_RST(8'd3)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_dat_o (rdat),
    .wb_we_i  (we),
    .wb_sel_i (sel),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (ack),
    .sd_ss    (ss),
    .sd_sck   (sck),
    .sd_mosi  (mosi),
    .sd_miso  (miso),
    .irq      (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Bus monitor: pops the expected response whenever an ack appears
  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (ack) begin
      if (ackq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack with no transaction pending");
      end else begin
        exp_t  e;
        string n;
        e = ackq.pop_front();
        n = nameq.pop_front();
        if (e.chk) check(n, rdat, e.val);
      end
      if (prev_ack) check("ack_single_cycle", 32'd1, 32'd0);
    end
    prev_ack = ack;
  end

  // SPI monitor: MOSI bit at each SCK rise and SCK high width
  logic prev_sck = 1'b0;
  int   hi_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sck = 1'b0;
      hi_cnt   = 0;
    end else begin
      if (sck && !prev_sck) begin
        if (bitq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sck: SCK rose with no bit expected");
        end else begin
          logic b;
          b = bitq.pop_front();
          check("mosi_bit", {31'd0, mosi}, {31'd0, b});
        end
      end
      if (sck) hi_cnt++;
      if (!sck && prev_sck) begin
        check("sck_high_width", hi_cnt, exp_hi);
        hi_cnt = 0;
      end
      prev_sck = sck;
    end
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic chk, input logic [31:0] ev, input string nm);
    int n;
    ackq.push_back('{chk: chk, val: ev});
    nameq.push_back(nm);
    @(negedge clk);
    we = w; adr = a; wdat = d; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 20);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout %s: got no ack expected ack within 20 cycles", nm);
      void'(ackq.pop_front());
      void'(nameq.pop_front());
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wb_xfer(1'b1, a, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ev, input string nm);
    wb_xfer(1'b0, a, 32'd0, 1'b1, ev, nm);
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
  endtask

  // Clocks from the start-accepting edge until irq is observed
  task automatic wait_irq(input int ev, input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!irq && n < 1000);
    check(nm, n, ev);
  endtask

  localparam logic [31:0] A_CTRL = 32'h0, A_DATA = 32'h4, A_STAT = 32'h8, A_RSVD = 32'hC;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ss",   {31'd0, ss},   32'd1);
    check("rst_sck",  {31'd0, sck},  32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd1);
    check("rst_ack",  {31'd0, ack},  32'd0);
    check("rst_irq",  {31'd0, irq},  32'd0);
    check("rst_dat",  rdat,          32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(A_CTRL, 32'h0000_0301, "ctrl_reset");
    rd(A_STAT, 32'h0, "status_reset");
    rd(A_DATA, 32'h0, "data_reset");

    // Reserved register: reads zero, writes ignored
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd(A_RSVD, 32'h0, "rsvd_read");
    rd(A_CTRL, 32'h0000_0301, "ctrl_after_rsvd_wr");

    // DIV=0, IE=1, SS=0, loopback 0xA5
    wr(A_CTRL, 32'h0000_0002);
    check("ss_low", {31'd0, ss}, 32'd0);
    rd(A_CTRL, 32'h0000_0002, "ctrl_readback");
    exp_hi = 1; loop_en = 1'b1;
    push_bits(8'hA5);
    wr(A_DATA, 32'h0000_00A5);
    wait_irq(17, "div0_done_clocks");
    rd(A_DATA, 32'h0000_00A5, "div0_rx");
    rd(A_STAT, 32'h2, "div0_status_done");
    wr(A_STAT, 32'h2);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd(A_STAT, 32'h0, "status_after_clear");

    // DIV=3, MISO tied high, send 0x00
    wr(A_CTRL, 32'h0000_0302);
    exp_hi = 4; loop_en = 1'b0; miso_tie = 1'b1;
    push_bits(8'h00);
    wr(A_DATA, 32'h0000_0000);
    wait_irq(65, "div3_busy_clocks");
    rd(A_DATA, 32'h0000_00FF, "div3_rx");
    wr(A_STAT, 32'h2);

    // Overrun: second DATA write while busy is dropped
    wr(A_CTRL, 32'h0000_0300);
    exp_hi = 4; loop_en = 1'b1;
    push_bits(8'h11);
    wr(A_DATA, 32'h0000_0011);
    wr(A_DATA, 32'h0000_0022);
    rd(A_STAT, 32'h5, "ovr_busy_status");
    repeat (80) @(negedge clk);
    rd(A_DATA, 32'h0000_0011, "ovr_rx_first_only");
    rd(A_STAT, 32'h6, "ovr_done_status");
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h2, "ovr_cleared");
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "all_cleared");

    // Reset in the middle of a transfer (during bit 3)
    wr(A_CTRL, 32'h0000_0000);
    exp_hi = 1; loop_en = 1'b1;
    push_bits(8'hC3);
    wr(A_DATA, 32'h0000_00C3);
    begin
      int rises, n;
      logic p;
      rises = 0; n = 0; p = sck;
      while (rises < 4 && n < 100) begin
        @(negedge clk);
        n++;
        if (sck && !p) rises++;
        p = sck;
      end
      check("reach_bit3", rises, 4);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss",   {31'd0, ss},   32'd1);
    check("abort_sck",  {31'd0, sck},  32'd0);
    check("abort_mosi", {31'd0, mosi}, 32'd1);
    check("abort_ack",  {31'd0, ack},  32'd0);
    check("abort_irq",  {31'd0, irq},  32'd0);
    bitq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    rd(A_STAT, 32'h0, "abort_status");
    rd(A_CTRL, 32'h0000_0301, "abort_ctrl");
    rd(A_DATA, 32'h0, "abort_rx");

    repeat (5) @(negedge clk);
    check("ackq_drained", ackq.size(), 0);
    check("bitq_drained", bitq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
